// File: rtl/spi_slave_if.sv
// ----------------------------------------------------------------------------
// spi_slave_if
//   Groups the SPI pins and the tx/rx valid-ready handshakes of spi_slave.
//
//   SPI pins      : sclk, cs (active low), mosi  -> slave
//                   miso, miso_oe                -> master
//   Transmit side : tx_data, tx_valid -> slave ; tx_ready -> producer
//   Receive side  : rx_data, rx_valid -> consumer ; rx_ready -> slave
//   Status        : busy, rx_overrun, tx_underrun (one-cycle pulses)
//
//   modport slave  : the spi_slave view
//   modport master : the environment view (SPI master plus tx/rx agents)
// ----------------------------------------------------------------------------
interface spi_slave_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  sclk;
  logic                  cs;
  logic                  mosi;
  logic                  miso;
  logic                  miso_oe;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  busy;
  logic                  rx_overrun;
  logic                  tx_underrun;

  modport slave (
    input  sclk, cs, mosi, tx_data, tx_valid, rx_ready,
    output miso, miso_oe, tx_ready, rx_data, rx_valid,
           busy, rx_overrun, tx_underrun
  );

  modport master (
    output sclk, cs, mosi, tx_data, tx_valid, rx_ready,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid,
           busy, rx_overrun, tx_underrun
  );
endinterface

// File: rtl/spi_slave.sv
// ----------------------------------------------------------------------------
// spi_slave
//   SPI mode-0 (CPOL=0, CPHA=0) responder. sclk, cs and mosi are
//   oversampled in the clk domain (sclk must be at most clk/8). Words are
//   received MSB first onto a valid/ready interface, and a word preloaded
//   into a one-entry holding register is shifted out on miso. Any number of
//   words may follow each other inside one cs-low frame.
//
//   Ports
//     clk   : system clock
//     reset : asynchronous, active-low reset
//     bus   : spi_slave_if.slave (SPI pins, tx/rx handshakes, status pulses)
// ----------------------------------------------------------------------------
module spi_slave #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  spi_slave_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Synchronisers and edge-detect history
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  logic                   r_cs_d;

  // Datapath
  logic [DATA_WIDTH-1:0]  r_hold;
  logic                   r_hold_full;
  logic [DATA_WIDTH-1:0]  r_tx_shift;
  logic [DATA_WIDTH-1:0]  r_rx_shift;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic                   r_reload_pend;
  logic                   r_underrun_pend;
  logic [DATA_WIDTH-1:0]  r_rx_data;
  logic                   r_rx_valid;
  logic                   r_rx_overrun;
  logic                   r_tx_underrun;

  logic                   w_sclk;
  logic                   w_cs;
  logic                   w_mosi;
  logic                   w_sclk_rise;
  logic                   w_sclk_fall;
  logic                   w_cs_rise;
  logic                   w_cs_fall;
  logic                   w_busy;
  logic                   w_load_frame;
  logic                   w_in_frame;
  logic                   w_bit_rise;
  logic                   w_bit_fall;
  logic                   w_word_done;
  logic                   w_tx_reload;
  logic                   w_hold_load;
  logic                   w_rx_free;
  logic [DATA_WIDTH-1:0]  w_rx_word;

  // --------------------------------------------------------------------------
  // Input synchronisers
  // --------------------------------------------------------------------------
  // NOTE: cs resets to its inactive level (1) so leaving reset never looks
  // like the start of a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value
      // of its neighbour, which is what turns this into a shift chain.
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   bus.cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      r_sclk_d    <= w_sclk;
      r_cs_d      <= w_cs;
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs        = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise =  w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk &  r_sclk_d;
  assign w_cs_rise   =  w_cs   & ~r_cs_d;
  assign w_cs_fall   = ~w_cs   &  r_cs_d;

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns the signal and no latch forms.
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_cs_fall) w_state_next = ST_ACTIVE;
      ST_ACTIVE: if (w_cs_rise) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  assign w_busy       = (r_state == ST_ACTIVE);
  assign w_load_frame = (r_state == ST_IDLE) && w_cs_fall;
  // sclk edges only count inside a frame that is not ending this cycle; an
  // sclk rise coinciding with the cs fall lands in IDLE and is ignored.
  assign w_in_frame   = w_busy && !w_cs_rise;
  assign w_bit_rise   = w_in_frame && w_sclk_rise;
  assign w_bit_fall   = w_in_frame && w_sclk_fall;
  assign w_word_done  = w_bit_rise && (r_bit_cnt == CNT_W'(DATA_WIDTH - 1));
  assign w_tx_reload  = w_load_frame || (w_bit_fall && r_reload_pend);
  assign w_hold_load  = bus.tx_valid && !r_hold_full;
  // Completion and consumption in the same cycle frees the slot for the new word.
  assign w_rx_free    = !r_rx_valid || bus.rx_ready;
  assign w_rx_word    = {r_rx_shift[DATA_WIDTH-2:0], w_mosi};

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold          <= '0;
      r_hold_full     <= 1'b0;
      r_tx_shift      <= '0;
      r_rx_shift      <= '0;
      r_bit_cnt       <= '0;
      r_reload_pend   <= 1'b0;
      r_underrun_pend <= 1'b0;
      r_rx_data       <= '0;
      r_rx_valid      <= 1'b0;
      r_rx_overrun    <= 1'b0;
      r_tx_underrun   <= 1'b0;
    end else begin
      r_rx_overrun  <= 1'b0;
      r_tx_underrun <= 1'b0;

      // Holding register: a load only happens when empty, so it can never
      // collide with the register being drained into the shifter.
      if (w_hold_load) begin
        r_hold      <= bus.tx_data;
        r_hold_full <= 1'b1;
      end else if (w_tx_reload) begin
        r_hold_full <= 1'b0;
      end

      // Transmit shifter: the MSB is on miso; shifting on the sclk fall puts
      // the next bit out well before the master samples on the next rise.
      if (w_tx_reload) begin
        r_tx_shift <= r_hold_full ? r_hold : '0;
      end else if (w_bit_fall) begin
        r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
      end

      // An empty holding register at frame start is an underrun right away.
      // At a word boundary the zero word is only reported once its first bit
      // is clocked, so the reload after a frame's last word stays silent.
      if (w_load_frame && !r_hold_full) r_tx_underrun <= 1'b1;
      if (w_bit_rise && r_underrun_pend) r_tx_underrun <= 1'b1;

      if (w_bit_fall && r_reload_pend && !r_hold_full) begin
        r_underrun_pend <= 1'b1;
      end else if (w_bit_rise || w_cs_rise) begin
        r_underrun_pend <= 1'b0;
      end

      if (w_word_done) begin
        r_reload_pend <= 1'b1;
      end else if (w_bit_fall || w_cs_rise) begin
        r_reload_pend <= 1'b0;
      end

      // Bit counter: cleared at frame start and end so a partial word is dropped.
      if (w_load_frame || w_cs_rise) begin
        r_bit_cnt <= '0;
      end else if (w_bit_rise) begin
        r_bit_cnt <= w_word_done ? '0 : r_bit_cnt + CNT_W'(1);
      end

      if (w_bit_rise) r_rx_shift <= w_rx_word;

      // Receive handshake
      if (w_word_done && w_rx_free) begin
        r_rx_data  <= w_rx_word;
        r_rx_valid <= 1'b1;
      end else begin
        if (w_word_done)              r_rx_overrun <= 1'b1;
        if (r_rx_valid && bus.rx_ready) r_rx_valid <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (all driven from flops)
  // --------------------------------------------------------------------------
  assign bus.miso        = w_busy & r_tx_shift[DATA_WIDTH-1];
  assign bus.miso_oe     = w_busy;
  assign bus.busy        = w_busy;
  assign bus.tx_ready    = ~r_hold_full;
  assign bus.rx_data     = r_rx_data;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.rx_overrun  = r_rx_overrun;
  assign bus.tx_underrun = r_tx_underrun;

endmodule

// File: tb/tb_spi_slave.sv
// ----------------------------------------------------------------------------
// tb_spi_slave
//   Bench for spi_slave: drives a mode-0 SPI master, a tx producer and an rx
//   consumer through spi_slave_if. Expected receive words are queued as the
//   master sends them and popped by a monitor whenever the DUT hands a word
//   over; expected miso words are queued when tx data is loaded.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_slave;
  localparam int DW   = 8;
  localparam int SYNC = 2;
  localparam int HALF = 6;   // clk cycles per sclk half period

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  spi_slave_if #(.DATA_WIDTH(DW)) bus();

  spi_slave #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int underrun_cnt = 0;
  int overrun_cnt  = 0;
  int rx_rise_cyc  = 0;
  int last_rise_cyc = 0;
  logic prev_rx_valid = 1'b0;
  logic [DW-1:0] mon_exp;
  logic [DW-1:0] exp_rx[$];
  logic [DW-1:0] exp_tx[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: status pulse counting and rx scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.tx_underrun) underrun_cnt++;
      if (bus.rx_overrun)  overrun_cnt++;
      if (bus.rx_valid && !prev_rx_valid) rx_rise_cyc = cyc;
      if (bus.rx_valid && bus.rx_ready) begin
        checks++;
        if (exp_rx.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected: got %h, no word expected", bus.rx_data);
        end else begin
          mon_exp = exp_rx.pop_front();
          if (bus.rx_data !== mon_exp) begin
            errors++;
            $display("FAIL rx_word: got %h, expected %h", bus.rx_data, mon_exp);
          end
        end
      end
    end
    prev_rx_valid = bus.rx_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- helpers
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cs_low();
    bus.cs = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_high();
    tick(HALF);
    bus.cs = 1'b1;
    tick(HALF);
  endtask

  // Mode-0 master: mosi changes while sclk is low, miso sampled on the rise.
  task automatic spi_bits(input logic [DW-1:0] d, input int n, output logic [DW-1:0] r);
    r = '0;
    for (int i = DW - 1; i >= DW - n; i--) begin
      bus.mosi = d[i];
      tick(HALF);
      bus.sclk = 1'b1;
      r[i] = bus.miso;
      last_rise_cyc = cyc;
      tick(HALF);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic load_tx(input logic [DW-1:0] d);
    int n = 0;
    while (!bus.tx_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (bus.tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_tx_wait: tx_ready=%b, expected 1", bus.tx_ready);
    end
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    exp_tx.push_back(d);
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    logic [DW+6:0] got;
    reset = 1'b0;
    tick(3);
    got = {bus.miso, bus.miso_oe, bus.tx_ready, bus.rx_valid, bus.busy,
           bus.rx_overrun, bus.tx_underrun, bus.rx_data};
    checks++;
    if (got !== {7'b0010000, 8'h00}) begin
      errors++;
      $display("FAIL reset_outputs: got %h, expected %h", got, {7'b0010000, 8'h00});
    end
    reset = 1'b1;
    tick(4);
    checks++;
    if (bus.busy !== 1'b0 || bus.tx_underrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%b underrun=%b, expected 0 0", bus.busy, bus.tx_underrun);
    end
  endtask

  task automatic test_single_word();
    logic [DW-1:0] got, exp;
    int lat;
    underrun_cnt = 0;
    bus.rx_ready = 1'b0;
    load_tx(8'hA5);
    checks++;
    if (bus.tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL tx_ready_loaded: got %b, expected 0", bus.tx_ready);
    end
    cs_low();
    checks++;
    if ({bus.busy, bus.miso_oe, bus.tx_ready} !== 3'b111) begin
      errors++;
      $display("FAIL frame_start: busy/oe/tx_ready=%b, expected 111", {bus.busy, bus.miso_oe, bus.tx_ready});
    end
    exp_rx.push_back(8'h3C);
    spi_bits(8'h3C, 8, got);
    cs_high();
    exp = exp_tx.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL miso_word_single: got %h, expected %h", got, exp);
    end
    checks++;
    if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h3C) begin
      errors++;
      $display("FAIL rx_single: valid=%b data=%h, expected 1 3c", bus.rx_valid, bus.rx_data);
    end
    lat = rx_rise_cyc - last_rise_cyc;
    checks++;
    if (lat < 1 || lat > SYNC + 2) begin
      errors++;
      $display("FAIL rx_latency: got %0d cycles, expected 1..%0d", lat, SYNC + 2);
    end
    checks++;
    if ({bus.busy, bus.miso_oe, bus.miso} !== 3'b000) begin
      errors++;
      $display("FAIL frame_end: busy/oe/miso=%b, expected 000", {bus.busy, bus.miso_oe, bus.miso});
    end
    bus.rx_ready = 1'b1;
    checks++;
    if (bus.rx_valid !== 1'b1) begin
      errors++;
      $display("FAIL rx_hold_before_ready: got %b, expected 1", bus.rx_valid);
    end
    tick();
    checks++;
    if (bus.rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rx_clear_after_ready: got %b, expected 0", bus.rx_valid);
    end
    bus.rx_ready = 1'b0;
    checks++;
    if (underrun_cnt !== 0) begin
      errors++;
      $display("FAIL underrun_single: got %0d pulses, expected 0", underrun_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] got0, got1, exp;
    underrun_cnt = 0;
    bus.rx_ready = 1'b1;
    load_tx(8'h12);
    cs_low();
    load_tx(8'h34);
    exp_rx.push_back(8'hF0);
    exp_rx.push_back(8'h0F);
    spi_bits(8'hF0, 8, got0);
    spi_bits(8'h0F, 8, got1);
    cs_high();
    exp = exp_tx.pop_front();
    checks++;
    if (got0 !== exp) begin
      errors++;
      $display("FAIL miso_b2b_word0: got %h, expected %h", got0, exp);
    end
    exp = exp_tx.pop_front();
    checks++;
    if (got1 !== exp) begin
      errors++;
      $display("FAIL miso_b2b_word1: got %h, expected %h", got1, exp);
    end
    for (int n = 0; n < 100 && exp_rx.size() != 0; n++) tick();
    checks++;
    if (exp_rx.size() != 0) begin
      errors++;
      $display("FAIL rx_b2b_drain: %0d words outstanding, expected 0", exp_rx.size());
    end
    checks++;
    if (underrun_cnt !== 0) begin
      errors++;
      $display("FAIL underrun_b2b: got %0d pulses, expected 0", underrun_cnt);
    end
    bus.rx_ready = 1'b0;
  endtask

  task automatic test_underrun();
    logic [DW-1:0] got;
    underrun_cnt = 0;
    bus.rx_ready = 1'b1;
    cs_low();
    checks++;
    if (underrun_cnt !== 1) begin
      errors++;
      $display("FAIL underrun_at_cs: got %0d pulses, expected 1", underrun_cnt);
    end
    exp_rx.push_back(8'h55);
    spi_bits(8'h55, 8, got);
    cs_high();
    checks++;
    if (got !== 8'h00) begin
      errors++;
      $display("FAIL miso_underrun: got %h, expected 00", got);
    end
    checks++;
    if (underrun_cnt !== 1) begin
      errors++;
      $display("FAIL underrun_total: got %0d pulses, expected 1", underrun_cnt);
    end
    for (int n = 0; n < 100 && exp_rx.size() != 0; n++) tick();
    checks++;
    if (exp_rx.size() != 0) begin
      errors++;
      $display("FAIL rx_underrun_drain: %0d words outstanding, expected 0", exp_rx.size());
    end
    bus.rx_ready = 1'b0;
  endtask

  task automatic test_overrun();
    logic [DW-1:0] got;
    overrun_cnt  = 0;
    bus.rx_ready = 1'b0;
    cs_low();
    spi_bits(8'hAA, 8, got);
    spi_bits(8'hBB, 8, got);
    cs_high();
    checks++;
    if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'hAA) begin
      errors++;
      $display("FAIL rx_overrun_keep: valid=%b data=%h, expected 1 aa", bus.rx_valid, bus.rx_data);
    end
    checks++;
    if (overrun_cnt !== 1) begin
      errors++;
      $display("FAIL overrun_count: got %0d pulses, expected 1", overrun_cnt);
    end
    exp_rx.push_back(8'hAA);
    bus.rx_ready = 1'b1;
    tick();
    checks++;
    if (bus.rx_valid !== 1'b0 || exp_rx.size() != 0) begin
      errors++;
      $display("FAIL rx_overrun_drain: valid=%b outstanding=%0d, expected 0 0", bus.rx_valid, exp_rx.size());
    end
    bus.rx_ready = 1'b0;
  endtask

  task automatic test_partial_word();
    logic [DW-1:0] got, exp;
    overrun_cnt  = 0;
    bus.rx_ready = 1'b0;
    cs_low();
    spi_bits(8'hFF, 5, got);
    cs_high();
    checks++;
    if (bus.rx_valid !== 1'b0 || overrun_cnt !== 0) begin
      errors++;
      $display("FAIL partial_discard: valid=%b overruns=%0d, expected 0 0", bus.rx_valid, overrun_cnt);
    end
    load_tx(8'h7E);
    bus.rx_ready = 1'b1;
    exp_rx.push_back(8'h81);
    cs_low();
    spi_bits(8'h81, 8, got);
    cs_high();
    exp = exp_tx.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL miso_after_partial: got %h, expected %h", got, exp);
    end
    for (int n = 0; n < 100 && exp_rx.size() != 0; n++) tick();
    checks++;
    if (exp_rx.size() != 0) begin
      errors++;
      $display("FAIL rx_after_partial: %0d words outstanding, expected 0", exp_rx.size());
    end
    bus.rx_ready = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic [DW-1:0] got, exp;
    logic [DW+6:0] outs;
    bus.rx_ready = 1'b0;
    cs_low();
    load_tx(8'h66);
    spi_bits(8'hC3, 3, got);
    reset = 1'b0;
    #1;
    outs = {bus.miso, bus.miso_oe, bus.tx_ready, bus.rx_valid, bus.busy,
            bus.rx_overrun, bus.tx_underrun, bus.rx_data};
    checks++;
    if (outs !== {7'b0010000, 8'h00}) begin
      errors++;
      $display("FAIL reset_mid_frame: got %h, expected %h", outs, {7'b0010000, 8'h00});
    end
    bus.sclk = 1'b0;
    bus.cs   = 1'b1;
    bus.mosi = 1'b0;
    exp_tx.delete();
    tick(2);
    reset = 1'b1;
    tick(4);
    load_tx(8'h5A);
    bus.rx_ready = 1'b1;
    exp_rx.push_back(8'hC3);
    cs_low();
    spi_bits(8'hC3, 8, got);
    cs_high();
    exp = exp_tx.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL miso_after_reset: got %h, expected %h", got, exp);
    end
    for (int n = 0; n < 100 && exp_rx.size() != 0; n++) tick();
    checks++;
    if (exp_rx.size() != 0) begin
      errors++;
      $display("FAIL rx_after_reset: %0d words outstanding, expected 0", exp_rx.size());
    end
    bus.rx_ready = 1'b0;
  endtask

  initial begin
    bus.sclk     = 1'b0;
    bus.cs       = 1'b1;
    bus.mosi     = 1'b0;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_underrun();
    test_overrun();
    test_partial_word();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI mode-0 (CPOL=0, CPHA=0) responder: the target-side counterpart of the team's SPI master.
- Samples the externally driven sclk, cs and mosi in the system clk domain, deserialises MSB-first words onto a valid/ready receive interface, and serialises a preloaded transmit word onto miso.
- Supports back-to-back words within one cs-low frame.

Parameters:
- DATA_WIDTH, 8, bits per SPI word.
- SYNC_STAGES, 2, flops in each synchroniser for sclk, cs and mosi (minimum 2).

Ports:
- clk  input  1  system clock; sclk frequency must be at most clk/8.
- reset  input  1  asynchronous, active-low reset.
- sclk  input  1  SPI clock from master (idle low).
- cs  input  1  chip select from master, active low.
- mosi  input  1  serial data from master.
- miso  output  1  serial data to master.
- miso_oe  output  1  miso output enable; high while the frame is active.
- tx_data  input  DATA_WIDTH  word to send in the next transfer.
- tx_valid  input  1  tx_data is valid; captured when tx_ready=1.
- tx_ready  output  1  transmit holding register is empty.
- rx_data  output  DATA_WIDTH  last received word.
- rx_valid  output  1  rx_data holds an unconsumed word.
- rx_ready  input  1  consumer accepts rx_data when rx_valid=1.
- busy  output  1  frame in progress (synchronised cs low).
- rx_overrun  output  1  one-cycle pulse: a word completed while rx_valid=1; that word is dropped.
- tx_underrun  output  1  one-cycle pulse: a word started with the holding register empty; 0 is sent.

Behaviour:
- Reset (reset=0, async): all outputs low except tx_ready=1. State IDLE; bit counter 0; shift registers 0; holding register empty.
- Synchronisation and edge detect:
  - sclk, cs and mosi each pass through SYNC_STAGES flops.
  - cs synchroniser resets to 1; the others reset to 0.
  - Rise/fall of sclk and cs are detected by comparing the synchronised value with a one-cycle-delayed copy.
- Transmit holding register: tx_valid && tx_ready loads it and clears tx_ready on the next cycle. tx_ready returns to 1 when the word moves into the tx shift register.
- State IDLE:
  - miso=0, miso_oe=0, busy=0.
  - On cs fall: go to ACTIVE, clear bit counter, load the tx shift register from the holding register.
  - If the holding register is empty, load 0 and pulse tx_underrun.
  - miso shows the shift MSB from the next cycle onward.
- State ACTIVE:
  - busy=1, miso_oe=1, miso = tx shift MSB (registered).
  - sclk rise: shift the synchronised mosi into the LSB of the rx shift register; increment the bit counter.
  - sclk fall: shift the tx register left by one (0 in), so the next bit is presented before the next rise.
  - On the sclk rise that brings the counter to DATA_WIDTH:
    - If rx_valid=0, transfer {rx_shift[DATA_WIDTH-2:0], mosi} to rx_data and set rx_valid next cycle.
    - If rx_valid=1 and rx_ready=0, pulse rx_overrun and leave rx_data unchanged.
    - Counter wraps to 0.
    - Tx shift register reloads from the holding register (underrun rule as above) on the following sclk fall instead of shifting.
  - On cs rise: return to IDLE.
    - A partial word is discarded, with no rx_valid and no overrun.
    - Counter is cleared. An undrained tx shift word is lost; the holding register is kept.
- rx handshake: rx_valid stays high until a cycle with rx_ready=1, then clears next cycle. If completion and consumption happen in the same cycle, the new word is accepted (no overrun), and rx_valid stays 1 with the new data.
- Latency: rx_valid rises at most SYNC_STAGES+2 clk cycles after the final sclk rising edge at the pin.
- sclk edges while cs is high are ignored. cs fall and sclk rise detected in the same cycle: the sclk edge is ignored (violates the master's setup timing).
- Reset asserted mid-frame: immediate return to reset state. The frame resumes only after a fresh cs fall.

Test Plan:
- Preload tx_data=0xA5, master sends 0x3C in one 8-bit frame -> master receives 0xA5; rx_data=0x3C and rx_valid=1 within 4 clk of the 8th rise; rx_valid clears one cycle after rx_ready.
- Two words in one frame, tx 0x12 then 0x34 (second loaded during word 1), mosi 0xF0, 0x0F -> miso yields 0x12, 0x34; rx_valid delivers 0xF0 then 0x0F; no underrun.
- No tx preload, frame of 0x55 -> tx_underrun pulses once at cs fall; miso all zeros; rx_data=0x55.
- Hold rx_ready=0 across two words 0xAA, 0xBB -> rx_data stays 0xAA; rx_overrun pulses once at completion of 0xBB.
- cs deasserted after 5 bits of 0xFF -> no rx_valid; next full frame 0x81 -> rx_data=0x81, so the counter restarted.
- reset pulsed low after bit 3 -> all outputs at reset values immediately, tx_ready=1; the subsequent clean frame transfers correctly.
